// File: rtl/mm_stream_arb_if.sv
// mm_stream_arb_if
//   Bundles the requester streams and the single merged output stream of
//   mm_stream_arb.
//   in_tdata   : NUM_REQ*D_W  requester data, requester i at [i*D_W +: D_W]
//   in_tvalid  : NUM_REQ      per-requester valid
//   in_tlast   : NUM_REQ      per-requester end-of-packet
//   in_tready  : NUM_REQ      per-requester ready (driven by arbiter)
//   out_tdata  : D_W          merged stream data
//   out_tvalid : 1            merged stream valid
//   out_tlast  : 1            merged stream end-of-packet
//   out_tid    : ID_W         requester index owning the output beat
//   out_tready : 1            downstream ready
//   slave  modport : arbiter view
//   master modport : environment view
interface mm_stream_arb_if #(
  parameter int D_W     = 8,
  parameter int NUM_REQ = 3
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ*D_W-1:0] in_tdata;
  logic [NUM_REQ-1:0]     in_tvalid;
  logic [NUM_REQ-1:0]     in_tlast;
  logic [NUM_REQ-1:0]     in_tready;
  logic [D_W-1:0]         out_tdata;
  logic                   out_tvalid;
  logic                   out_tlast;
  logic [ID_W-1:0]        out_tid;
  logic                   out_tready;

  modport slave (
    input  in_tdata, in_tvalid, in_tlast, out_tready,
    output in_tready, out_tdata, out_tvalid, out_tlast, out_tid
  );

  modport master (
    output in_tdata, in_tvalid, in_tlast, out_tready,
    input  in_tready, out_tdata, out_tvalid, out_tlast, out_tid
  );
endinterface

// File: rtl/mm_stream_arb.sv
// mm_stream_arb
//   Packet-granular round-robin arbiter merging NUM_REQ streams into one
//   registered output stream. A grant is made in IDLE (one bubble cycle),
//   then the winner owns the output until it delivers tlast.
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   enable_i    : permits new grants; an open packet always completes
//   busy_o      : high while a requester is locked
//   pkt_count_o : completed output packets, wraps
//   bus         : stream bundle (slave modport)
module mm_stream_arb #(
  parameter int D_W     = 8,
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] pkt_count_o,
  mm_stream_arb_if.slave   bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    sel_q, sel_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [D_W-1:0]     out_tdata_q, out_tdata_d;
  logic               out_tvalid_q, out_tvalid_d;
  logic               out_tlast_q, out_tlast_d;
  logic [ID_W-1:0]    out_tid_q, out_tid_d;
  logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;

  logic [NUM_REQ-1:0] in_tready_s;
  logic               grant_found_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic [ID_W:0]      cand_s;
  logic               accept_s;
  logic               sel_last_s;
  logic [D_W-1:0]     sel_data_s;
  logic               out_hs_s;

  // Round-robin search: first valid requester at or after rr_ptr, cyclic.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand_s >= (ID_W+1)'(NUM_REQ)) begin
        cand_s = cand_s - (ID_W+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && bus.in_tvalid[cand_s[ID_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[ID_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Ready/handshake decode; only the locked requester may see ready.
  always_comb begin
    in_tready_s = '0;
    if (state_q == ST_LOCKED) begin
      in_tready_s[sel_q] = ~out_tvalid_q | bus.out_tready;
    end else begin
      in_tready_s = '0;
    end
    accept_s   = bus.in_tvalid[sel_q] & in_tready_s[sel_q];
    sel_last_s = bus.in_tlast[sel_q];
    sel_data_s = bus.in_tdata[sel_q*D_W +: D_W];
    out_hs_s   = out_tvalid_q & bus.out_tready;
  end

  // FSM next state: grant in IDLE, release on the accepted tlast beat.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i && grant_found_s) begin
          state_d = ST_LOCKED;
          sel_d   = grant_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (accept_s && sel_last_s) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (sel_q == ID_W'(NUM_REQ-1)) ? '0 : sel_q + ID_W'(1);
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register next state; payload holds while stalled.
  always_comb begin
    out_tdata_d  = out_tdata_q;
    out_tvalid_d = out_tvalid_q;
    out_tlast_d  = out_tlast_q;
    out_tid_d    = out_tid_q;
    if (accept_s) begin
      out_tdata_d  = sel_data_s;
      out_tvalid_d = 1'b1;
      out_tlast_d  = sel_last_s;
      out_tid_d    = sel_q;
    end else if (bus.out_tready) begin
      out_tvalid_d = 1'b0;
    end else begin
      out_tvalid_d = out_tvalid_q;
    end
    if (out_hs_s && out_tlast_q) begin
      pkt_count_d = pkt_count_q + CNT_W'(1);
    end else begin
      pkt_count_d = pkt_count_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      rr_ptr_q     <= '0;
      out_tdata_q  <= '0;
      out_tvalid_q <= 1'b0;
      out_tlast_q  <= 1'b0;
      out_tid_q    <= '0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      rr_ptr_q     <= rr_ptr_d;
      out_tdata_q  <= out_tdata_d;
      out_tvalid_q <= out_tvalid_d;
      out_tlast_q  <= out_tlast_d;
      out_tid_q    <= out_tid_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign bus.in_tready  = in_tready_s;
  assign bus.out_tdata  = out_tdata_q;
  assign bus.out_tvalid = out_tvalid_q;
  assign bus.out_tlast  = out_tlast_q;
  assign bus.out_tid    = out_tid_q;
  assign busy_o         = (state_q == ST_LOCKED);
  assign pkt_count_o    = pkt_count_q;
endmodule
